junction_scheduler: RTL and testbench
=====================================

// Module: junction_scheduler
//
// PURPOSE
//   Shares one road junction between two Traffic_Light units, A and B.
//   - Each unit has its own request button (req_a / req_b).
//   - The scheduler latches requests and arbitrates round-robin.
//   - It issues a single-cycle start pulse to the granted unit, then times that
//     unit's light sequence and an all-red clearance gap before the next grant.
//   - It sits above the two Traffic_Light instances and drives their start inputs.
//
// PARAMETERS
//   RUN_TICKS    11  clocks the granted light sequence is allowed to run (>=1)
//   CLEAR_TICKS  2   all-red clearance clocks after each run (>=1)
//   CNT_W        8   counter width; must hold max(RUN_TICKS,CLEAR_TICKS)-1
//
// PORTS
//   clock      in   1  system clock, rising edge
//   reset      in   1  synchronous, active-high reset
//   req_a      in   1  request from side A (level; rising edge = one request)
//   req_b      in   1  request from side B
//   start_a    out  1  one-cycle start pulse to Traffic_Light A
//   start_b    out  1  one-cycle start pulse to Traffic_Light B
//   grant_a    out  1  side A owns junction (START+RUN)
//   grant_b    out  1  side B owns junction (START+RUN)
//   all_red    out  1  clearance gap active (CLEAR)
//   busy       out  1  state != IDLE
//   pending    out  2  {pend_b, pend_a} latched requests
//
// BEHAVIOUR
//   Reset
//   - Synchronous, active-high; takes priority over everything.
//   - Next edge: state=IDLE, cnt=0, pending=0, req_q=2'b00, last=B.
//     All outputs 0.
//   - Reset mid-run aborts the run; no further start pulse is issued.
//   Requests
//   - req_q registers req each cycle; rise_x = req_x & ~req_q_x.
//   - pend_x set on rise_x; cleared at the edge leaving START while grant==x.
//   - Set wins over clear in the same cycle, so a new press is kept.
//   - A held req counts once. Req high at reset release counts as one request.
//   States (outputs are decoded from registered state/grant only)
//   - IDLE:
//     - no pending -> stay.
//     - One pending -> grant it.
//     - Both pending -> grant side != last; after reset, A wins the first tie.
//     - Next state START.
//   - START: start_x=1 for exactly one cycle; cnt<=RUN_TICKS-1; last<=grant; next RUN.
//   - RUN: grant_x=1; cnt decrements; at cnt==0 -> CLEAR with cnt<=CLEAR_TICKS-1.
//   - CLEAR: all_red=1, grant_*=0; cnt decrements; at cnt==0 -> IDLE.
//   Timing and invariants
//   - Latency: rise seen at edge k -> pend at k -> START at k+1 -> start_x high for cycle k+1..k+2.
//   - One grant occupies 1+RUN_TICKS+CLEAR_TICKS cycles, with busy high throughout.
//   - Back-to-back: if pending is nonzero on return to IDLE, START follows after one IDLE cycle.
//   - Never both grant_a&grant_b, nor both start_a&start_b, nor all_red with any grant.
//   - Counter never wraps; illegal state encodings -> IDLE.
//
// TESTING  (bench: 100ns clock, RUN_TICKS=4, CLEAR_TICKS=2)
//   1. Reset held 2 cycles, req_a=req_b=0 -> all outputs 0, pending=00, busy=0 indefinitely.
//   2. req_a pulsed 1 cycle -> start_a 1 cycle two edges later, grant_a 5 cycles,
//      all_red 2 cycles, busy 7 cycles total, pending 00 after.
//   3. req_a and req_b rise same cycle -> A served first, then one IDLE cycle, then B;
//      start_a and start_b never overlap.
//   4. req_b held high 30 cycles -> exactly one start_b. New req_b rise during B's RUN
//      -> pend_b=1 and a second B grant after CLEAR.
//   5. reset asserted in RUN cycle 2 -> next edge IDLE, outputs 0, pending 00; no start issued after.
//   6. Alternating ties (both pressed again during each CLEAR) -> grants A,B,A,B.

Source files
------------

// File: rtl/junction_scheduler.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// junction_scheduler
//
// Shares one road junction between two Traffic_Light units, A and B.
// Requests are edge-detected and latched, then arbitrated round-robin.
// The granted unit receives a one-cycle start pulse. The scheduler then times
// the unit's light sequence (RUN) and an all-red clearance gap (CLEAR) before
// it returns to IDLE and can issue the next grant.
//
// Handshake: there is no back-pressure. A request is a rising edge on req_x.
// It is held in pending[x] until the grant to side x leaves START. A new rising
// edge in that same cycle keeps pending[x] set.
//
// Ports
//   clock    in   1  system clock, rising edge
//   reset    in   1  synchronous, active-high reset
//   req_a    in   1  request from side A (level; rising edge = one request)
//   req_b    in   1  request from side B
//   start_a  out  1  one-cycle start pulse to Traffic_Light A
//   start_b  out  1  one-cycle start pulse to Traffic_Light B
//   grant_a  out  1  side A owns the junction (START + RUN)
//   grant_b  out  1  side B owns the junction (START + RUN)
//   all_red  out  1  clearance gap active (CLEAR)
//   busy     out  1  scheduler is not IDLE
//   pending  out  2  {pend_b, pend_a} latched requests
// -----------------------------------------------------------------------------
module junction_scheduler #(
  parameter int RUN_TICKS   = 11,
  parameter int CLEAR_TICKS = 2,
  parameter int CNT_W       = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_a,
  input  logic       req_b,
  output logic       start_a,
  output logic       start_b,
  output logic       grant_a,
  output logic       grant_b,
  output logic       all_red,
  output logic       busy,
  output logic [1:0] pending
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    CLEAR = 2'd3
  } state_t;

  // Side encoding used by gnt/last: 0 = A, 1 = B.
  localparam logic SIDE_A = 1'b0;
  localparam logic SIDE_B = 1'b1;

  // Reload values. The counter counts down to zero, so a phase lasts load+1 cycles.
  localparam logic [CNT_W-1:0] RUN_LOAD   = CNT_W'(RUN_TICKS - 1);
  localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = '0;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       pend_q, pend_d;
  logic [1:0]       req_q;
  logic             last_q, last_d;
  logic             gnt_q, gnt_d;

  logic [1:0]       rise;
  logic [1:0]       pend_clr;

  // Internal visibility of the FSM state, kept under a stable name.
  state_t           state_dbg;
  assign state_dbg = state_q;

  // Sequential state
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= 2'b00;
      req_q   <= 2'b00;
      last_q  <= SIDE_B;  // makes A win the first tie after reset
      gnt_q   <= SIDE_A;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      req_q   <= {req_b, req_a};
      last_q  <= last_d;
      gnt_q   <= gnt_d;
    end
  end

  // Next-state logic, arbitration and request bookkeeping
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    gnt_d    = gnt_q;
    pend_clr = 2'b00;

    // req_q is cleared by reset. A level already high at release therefore
    // shows up as one rise.
    rise = {req_b, req_a} & ~req_q;

    case (state_q)
      IDLE: begin
        if (pend_q != 2'b00) begin
          state_d = START;
          cnt_d   = CNT_ZERO;
          if (pend_q == 2'b11) begin
            gnt_d = ~last_q;      // tie: serve the side not served last
          end else begin
            gnt_d = pend_q[1];    // only one side is pending: that side
          end
        end
      end

      START: begin
        state_d  = RUN;
        cnt_d    = RUN_LOAD;
        last_d   = gnt_q;
        pend_clr = (gnt_q == SIDE_B) ? 2'b10 : 2'b01;
      end

      RUN: begin
        if (cnt_q == CNT_ZERO) begin
          state_d = CLEAR;
          cnt_d   = CLEAR_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      CLEAR: begin
        if (cnt_q == CNT_ZERO) begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase

    // Set wins over clear, so a press in the START cycle is not lost.
    pend_d = (pend_q & ~pend_clr) | rise;
  end

  // Outputs are decoded only from registered state and grant.
  assign start_a = (state_q == START) && (gnt_q == SIDE_A);
  assign start_b = (state_q == START) && (gnt_q == SIDE_B);
  assign grant_a = ((state_q == START) || (state_q == RUN)) && (gnt_q == SIDE_A);
  assign grant_b = ((state_q == START) || (state_q == RUN)) && (gnt_q == SIDE_B);
  assign all_red = (state_q == CLEAR);
  assign busy    = (state_q != IDLE);
  assign pending = pend_q;

endmodule

// File: tb/tb_junction_scheduler.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_junction_scheduler
//
// Bench for junction_scheduler with RUN_TICKS=4, CLEAR_TICKS=2 and a 100 ns
// clock. The reference model tracks each grant by its age in cycles since the
// START cycle. Expected outputs are derived from that age.
// -----------------------------------------------------------------------------
module tb_junction_scheduler;

  localparam int RUN   = 4;
  localparam int CLR   = 2;
  localparam int TOTAL = 1 + RUN + CLR;
  localparam int W     = 1;

  // Clock / reset
  logic       clock;
  logic       reset;
  logic       req_a, req_b;
  logic       start_a, start_b, grant_a, grant_b, all_red, busy;
  logic [1:0] pending;

  initial clock = 1'b0;
  always #50 clock = ~clock;

  junction_scheduler #(
    .RUN_TICKS  (RUN),
    .CLEAR_TICKS(CLR),
    .CNT_W      (8)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .req_a  (req_a),
    .req_b  (req_b),
    .start_a(start_a),
    .start_b(start_b),
    .grant_a(grant_a),
    .grant_b(grant_b),
    .all_red(all_red),
    .busy   (busy),
    .pending(pending)
  );

  // Scoreboard state
  int n_cmp = 0;
  int n_err = 0;
  int cnt_sa = 0;
  int cnt_sb = 0;
  bit track = 1'b0;
  logic [W-1:0] exp_q[$];   // expected grant order, 0 = A, 1 = B

  // Reference model: age = -1 when idle, otherwise cycles since START.
  int         m_age;
  logic [1:0] m_pend;
  logic [1:0] m_reqq;
  logic       m_last;
  logic       m_side;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic a, input logic b);
    logic [1:0] rise;
    if (r) begin
      m_pend = 2'b00;
      m_reqq = 2'b00;
      m_last = 1'b1;
      m_age  = -1;
      m_side = 1'b0;
    end else begin
      rise   = {b, a} & ~m_reqq;
      m_reqq = {b, a};
      if (m_age < 0) begin
        if (m_pend != 2'b00) begin
          if (m_pend == 2'b11)  m_side = ~m_last;
          else if (m_pend[0])   m_side = 1'b0;
          else                  m_side = 1'b1;
          m_age = 0;
        end
      end else begin
        if (m_age == 0) begin
          m_pend[m_side] = 1'b0;
          m_last = m_side;
        end
        if (m_age == TOTAL - 1) m_age = -1;
        else                    m_age = m_age + 1;
      end
      m_pend = m_pend | rise;
    end
  endtask

  task automatic compare_all();
    logic [7:0] exp_v, got_v;
    logic e_sa, e_sb, e_ga, e_gb, e_ar, e_by;
    logic [W-1:0] want;
    e_sa = (m_age == 0) && !m_side;
    e_sb = (m_age == 0) && m_side;
    e_ga = (m_age >= 0) && (m_age <= RUN) && !m_side;
    e_gb = (m_age >= 0) && (m_age <= RUN) && m_side;
    e_ar = (m_age > RUN);
    e_by = (m_age >= 0);
    exp_v = {e_sa, e_sb, e_ga, e_gb, e_ar, e_by, m_pend};
    got_v = {start_a, start_b, grant_a, grant_b, all_red, busy, pending};
    check("outputs", got_v, exp_v);
    check("inv_two_grants", {7'd0, grant_a & grant_b}, 8'd0);
    check("inv_two_starts", {7'd0, start_a & start_b}, 8'd0);
    check("inv_red_grant",  {7'd0, all_red & (grant_a | grant_b)}, 8'd0);
    if (start_a === 1'b1) cnt_sa++;
    if (start_b === 1'b1) cnt_sb++;
    if (track && (start_a === 1'b1 || start_b === 1'b1)) begin
      if (exp_q.size() == 0) begin
        check("order_unexpected", {7'd0, start_b}, 8'hff);
      end else begin
        want = exp_q.pop_front();
        check("order", {7'd0, start_b}, {7'd0, want});
      end
    end
  endtask

  // Driver: inputs change on the falling edge, outputs sampled 1 ns after rise.
  task automatic step(input logic r, input logic a, input logic b);
    reset = r;
    req_a = a;
    req_b = b;
    @(posedge clock);
    model_edge(r, a, b);
    #1;
    compare_all();
    @(negedge clock);
  endtask

  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    req_a = 1'b0;
    req_b = 1'b0;
    m_age = -1; m_pend = 2'b00; m_reqq = 2'b00; m_last = 1'b1; m_side = 1'b0;
    @(negedge clock);

    // 1: reset held two cycles, then idle
    do_reset(2);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b0);
    check("idle_no_start", 8'(cnt_sa + cnt_sb), 8'd0);

    // 2: single A pulse
    cnt_sa = 0;
    step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b0);
    check("single_a_starts", 8'(cnt_sa), 8'd1);

    // 3: simultaneous rise, A first then B
    do_reset(1);
    track = 1'b1;
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0);
    check("tie_queue_empty", 8'(exp_q.size()), 8'd0);
    track = 1'b0;

    // 4: held B counts once; re-press during RUN gives a second grant
    do_reset(1);
    cnt_sb = 0;
    for (int i = 0; i < 30; i++) step(1'b0, 1'b0, 1'b1);
    check("held_b_once", 8'(cnt_sb), 8'd1);
    step(1'b0, 1'b0, 1'b0);
    cnt_sb = 0;
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10 && m_age != 2; i++) step(1'b0, 1'b0, 1'b0);
    check("reached_run", 8'(m_age), 8'd2);
    step(1'b0, 1'b0, 1'b1);
    check("pend_b_in_run", {6'd0, pending}, 8'b10);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0);
    check("second_b_grant", 8'(cnt_sb), 8'd2);

    // 5: reset in RUN cycle 2 aborts the run
    do_reset(1);
    step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10 && m_age != 2; i++) step(1'b0, 1'b0, 1'b0);
    check("reached_run2", 8'(m_age), 8'd2);
    step(1'b1, 1'b0, 1'b0);
    check("abort_busy", {7'd0, busy}, 8'd0);
    cnt_sa = 0;
    cnt_sb = 0;
    for (int i = 0; i < 15; i++) step(1'b0, 1'b0, 1'b0);
    check("abort_no_start", 8'(cnt_sa + cnt_sb), 8'd0);

    // 6: both pressed again during CLEAR -> alternating grants
    do_reset(1);
    track = 1'b1;
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);   // leftover A request from the third re-press
    step(1'b0, 1'b1, 1'b1);
    begin
      int presses = 0;
      for (int i = 0; i < 60; i++) begin
        if (m_age == RUN + 1 && presses < 3) begin
          presses++;
          step(1'b0, 1'b1, 1'b1);
        end else begin
          step(1'b0, 1'b0, 1'b0);
        end
      end
    end
    check("alt_queue_empty", 8'(exp_q.size()), 8'd0);
    track = 1'b0;

    // Random traffic with occasional resets
    do_reset(1);
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 63) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
